// File: rtl/sdm_pkg.sv
// Shared definitions for the sigma-delta audio path.
//
// Contents:
//   SDM_AUDIO_W  - PCM word width used on both sides of the converter.
//   cic_width()  - internal CIC register width for a given order / decimation.
//   sat_shift()  - arithmetic shift right (left when shift is negative)
//                  followed by saturation to a signed out_w-bit range.
//
// Both functions are also used by the modulator-side bench models, so they
// are kept generic (wide signed operands, integer parameters).
package sdm_pkg;

    localparam int SDM_AUDIO_W = 16;

    // Worst-case CIC gain is R^ORDER on a +/-1 input, so ORDER*LOG2_R bits
    // of growth plus 2 bits for the signed input value.
    function automatic int cic_width(input int order, input int log2_r);
        return 2 + order * log2_r;
    endfunction

    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] value,
        input int                 shift,
        input int                 out_w
    );
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        if (shift >= 0) begin
            shifted = value >>> shift;
        end else begin
            shifted = value <<< (-shift);
        end
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (shifted > max_v) begin
            return max_v;
        end else if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/sdm_cic_comb_stage.sv
// One registered CIC comb (differentiator) stage at the decimated rate.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_data carries a decimated word this cycle
//   in_data    in   W-bit word (modulo 2^W arithmetic)
//   out_valid  out  in_valid delayed by one cycle
//   out_data   out  in_data minus the previous accepted in_data
//
// The delay register only advances on valid words, so idle cycles between
// decimated samples do not disturb the difference.
module sdm_cic_comb_stage #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [W-1:0] delay_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delay_reg <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data  <= in_data - delay_reg;
                delay_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/sdm_cic_decimator.sv
// CIC decimator turning a 1-bit sigma-delta bitstream into signed PCM.
//
// Chain: ORDER integrators at the input rate -> decimate by 2^LOG2_R ->
// ORDER registered comb stages -> shift/saturate to OUT_W bits (registered).
// The first ORDER decimated words after reset are start-up transients and
// are suppressed.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   valid_in   in   sdm_in carries a new bitstream sample this cycle
//   sdm_in     in   bitstream sample (1 -> +1, 0 -> -1)
//   valid_out  out  one-cycle strobe, audio_out holds a new word
//   audio_out  out  signed PCM, held between strobes
module sdm_cic_decimator
    import sdm_pkg::*;
#(
    parameter int ORDER  = 3,
    parameter int LOG2_R = 6,
    parameter int OUT_W  = SDM_AUDIO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             sdm_in,
    output logic             valid_out,
    output logic [OUT_W-1:0] audio_out
);

    localparam int W      = cic_width(ORDER, LOG2_R);
    localparam int SHIFT  = ORDER * LOG2_R + 1 - OUT_W;
    localparam int WARM_W = $clog2(ORDER + 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(ORDER);

    // ---------------------------------------------------------------
    // Integrators (input rate). Wrap-around is harmless: the combs
    // take differences modulo 2^W and the wraps cancel.
    // ---------------------------------------------------------------
    logic [W-1:0] x;
    logic [W-1:0] integ_reg [ORDER];

    assign x = sdm_in ? W'(1) : '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ORDER; i++) begin
                integ_reg[i] <= '0;
            end
        end else if (valid_in) begin
            integ_reg[0] <= integ_reg[0] + x;
            for (int i = 1; i < ORDER; i++) begin
                integ_reg[i] <= integ_reg[i] + integ_reg[i-1];
            end
        end
    end

    // ---------------------------------------------------------------
    // Decimation: every R-th accepted sample captures the last
    // integrator into the comb pipeline.
    // ---------------------------------------------------------------
    logic [LOG2_R-1:0] dec_cnt_reg;
    logic              strobe;
    logic              cap_valid_reg;
    logic [W-1:0]      cap_data_reg;

    assign strobe = valid_in && (dec_cnt_reg == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_cnt_reg   <= '0;
            cap_valid_reg <= 1'b0;
            cap_data_reg  <= '0;
        end else begin
            cap_valid_reg <= strobe;
            if (valid_in) begin
                dec_cnt_reg <= dec_cnt_reg + LOG2_R'(1);
            end
            if (strobe) begin
                cap_data_reg <= integ_reg[ORDER-1];
            end
        end
    end

    // ---------------------------------------------------------------
    // Comb pipeline: one stage per cycle, so back-to-back decimated
    // words never collide.
    // ---------------------------------------------------------------
    logic [ORDER:0]        comb_valid;
    logic [ORDER:0][W-1:0] comb_data;

    assign comb_valid[0] = cap_valid_reg;
    assign comb_data[0]  = cap_data_reg;

    generate
        for (genvar gi = 0; gi < ORDER; gi++) begin : g_comb
            sdm_cic_comb_stage #(
                .W(W)
            ) u_comb (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (comb_valid[gi]),
                .in_data   (comb_data[gi]),
                .out_valid (comb_valid[gi+1]),
                .out_data  (comb_data[gi+1])
            );
        end
    endgenerate

    // ---------------------------------------------------------------
    // Output stage with warm-up suppression.
    // ---------------------------------------------------------------
    logic [WARM_W-1:0] warm_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm_reg  <= '0;
            valid_out <= 1'b0;
            audio_out <= '0;
        end else begin
            valid_out <= 1'b0;
            if (comb_valid[ORDER]) begin
                if (warm_reg != WARM_DONE) begin
                    warm_reg <= warm_reg + WARM_W'(1);
                end else begin
                    valid_out <= 1'b1;
                    audio_out <= OUT_W'(sat_shift(64'(signed'(comb_data[ORDER])),
                                                  SHIFT, OUT_W));
                end
            end
        end
    end

endmodule
